// File: rtl/alu_sequencer.sv
// alu_sequencer: turns one ALU operation request into the cpu6502 ALU
// select/operand/function strobes (one or two passes), captures the ADD
// hold register and returns result, N, Z, carry and error on a valid/ready
// response port. Carry, N and Z are computed here because the ALU does not
// produce carry or overflow.
//
// Optional build macro: ALU_SEQUENCER_ROTATE_EN
//   defined   -> ops 9 (ROL) and 10 (ROR) are legal and use a second ORS pass
//   undefined -> ops 9 and 10 are rejected with the one-cycle error response
module alu_sequencer (
    input  logic       i_clk,
    input  logic       i_reset_n,
    // command port
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [3:0] i_cmd_op,
    input  logic [7:0] i_cmd_a,
    input  logic [7:0] i_cmd_b,
    input  logic       i_cmd_c,
    // ALU drive
    output logic [7:0] o_db,
    output logic       o_db_add,
    output logic       o_db_n_add,
    output logic       o_0_add,
    output logic [7:0] o_sb,
    output logic       o_sb_add,
    output logic       o_sums,
    output logic       o_ands,
    output logic       o_eors,
    output logic       o_ors,
    output logic       o_srs,
    output logic       o_1_addc,
    input  logic [7:0] i_add,
    // response port
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_n,
    output logic       o_rsp_z,
    output logic       o_rsp_c,
    output logic       o_rsp_err
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_INC = 4'd7;
    localparam logic [3:0] OP_DEC = 4'd8;
    localparam logic [3:0] OP_ROL = 4'd9;
    localparam logic [3:0] OP_ROR = 4'd10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PASS1   = 3'd1,
        PASS2   = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       accept;
    logic [3:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       cin_q;
    logic [7:0] result_q;
    logic       n_q;
    logic       z_q;
    logic       cout_q;
    logic       err_q;

    function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_SEQUENCER_ROTATE_EN
        return (op <= OP_ROR);
`else
        return (op <= OP_DEC);
`endif
    endfunction

    // Carry-in only adds a second pass for ADD/SUB (+1) and the rotates (OR in the bit).
    function automatic logic needs_pass2(input logic [3:0] op, input logic c);
        logic two;
        two = (op == OP_ADD) || (op == OP_SUB);
`ifdef ALU_SEQUENCER_ROTATE_EN
        two = two || (op == OP_ROL) || (op == OP_ROR);
`endif
        return two & c;
    endfunction

    // The ALU never reports carry, so it is worked out from the operands here.
    function automatic logic carry_out(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic c);
        logic [8:0] sum;
        logic       co;
        sum = 9'd0;
        co  = c;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b} + {8'd0, c};
                co  = sum[8];
            end
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + {8'd0, c};
                co  = sum[8];
            end
            OP_ASL, OP_ROL: co = a[7];
            OP_LSR, OP_ROR: co = a[0];
            default:        co = c;
        endcase
        return co;
    endfunction

    assign accept      = i_cmd_valid & o_cmd_ready;
    assign o_cmd_ready = (state_q == IDLE);
    assign o_rsp_valid = (state_q == RESP);
    assign o_0_add     = 1'b0;
    assign o_1_addc    = 1'b0;
    assign o_rsp_data  = result_q;
    assign o_rsp_n     = n_q;
    assign o_rsp_z     = z_q;
    assign o_rsp_c     = cout_q;
    assign o_rsp_err   = err_q;

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Latch the command on accept and capture the ALU result with its flags.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            op_q     <= 4'd0;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            cin_q    <= 1'b0;
            result_q <= 8'd0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= i_cmd_op;
                a_q   <= i_cmd_a;
                b_q   <= i_cmd_b;
                cin_q <= i_cmd_c;
                if (op_legal(i_cmd_op)) begin
                    err_q  <= 1'b0;
                    cout_q <= carry_out(i_cmd_op, i_cmd_a, i_cmd_b, i_cmd_c);
                end else begin
                    err_q    <= 1'b1;
                    cout_q   <= 1'b0;
                    result_q <= 8'd0;
                    n_q      <= 1'b0;
                    z_q      <= 1'b0;
                end
            end
            if (state_q == CAPTURE) begin
                result_q <= i_add;
                n_q      <= i_add[7];
                z_q      <= (i_add == 8'd0);
            end
        end
    end

    // Next state and ALU drive; everything idles at zero outside the passes.
    always_comb begin
        state_d    = state_q;
        o_db       = 8'd0;
        o_db_add   = 1'b0;
        o_db_n_add = 1'b0;
        o_sb       = 8'd0;
        o_sb_add   = 1'b0;
        o_sums     = 1'b0;
        o_ands     = 1'b0;
        o_eors     = 1'b0;
        o_ors      = 1'b0;
        o_srs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = op_legal(i_cmd_op) ? PASS1 : RESP;
            end
            PASS1: begin
                state_d  = needs_pass2(op_q, cin_q) ? PASS2 : CAPTURE;
                o_sb     = a_q;
                o_sb_add = 1'b1;
                case (op_q)
                    OP_ADD: begin o_db = b_q;   o_db_add   = 1'b1; o_sums = 1'b1; end
                    OP_SUB: begin o_db = b_q;   o_db_n_add = 1'b1; o_sums = 1'b1; end
                    OP_AND: begin o_db = b_q;   o_db_add   = 1'b1; o_ands = 1'b1; end
                    OP_OR:  begin o_db = b_q;   o_db_add   = 1'b1; o_ors  = 1'b1; end
                    OP_EOR: begin o_db = b_q;   o_db_add   = 1'b1; o_eors = 1'b1; end
                    OP_ASL: begin o_db = a_q;   o_db_add   = 1'b1; o_sums = 1'b1; end
                    OP_LSR: begin o_db = a_q;   o_db_add   = 1'b1; o_srs  = 1'b1; end
                    OP_INC: begin o_db = 8'h01; o_db_add   = 1'b1; o_sums = 1'b1; end
                    OP_DEC: begin o_db = 8'hFF; o_db_add   = 1'b1; o_sums = 1'b1; end
`ifdef ALU_SEQUENCER_ROTATE_EN
                    OP_ROL: begin o_db = a_q;   o_db_add   = 1'b1; o_sums = 1'b1; end
                    OP_ROR: begin o_db = a_q;   o_db_add   = 1'b1; o_srs  = 1'b1; end
`endif
                    default: ;
                endcase
            end
            PASS2: begin
                // Second pass feeds the first-pass result back on SB.
                state_d  = CAPTURE;
                o_sb     = i_add;
                o_sb_add = 1'b1;
                case (op_q)
                    OP_ADD, OP_SUB: begin o_db = 8'h01; o_db_add = 1'b1; o_sums = 1'b1; end
`ifdef ALU_SEQUENCER_ROTATE_EN
                    OP_ROL: begin o_db = 8'h01; o_db_add = 1'b1; o_ors = 1'b1; end
                    OP_ROR: begin o_db = 8'h80; o_db_add = 1'b1; o_ors = 1'b1; end
`endif
                    default: ;
                endcase
            end
            CAPTURE: state_d = RESP;
            RESP: begin
                if (i_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: bench for alu_sequencer with a behavioural cpu6502 ALU
// stand-in driving i_add and an operation-level reference model.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_c;
    logic [7:0] o_db;
    logic       o_db_add;
    logic       o_db_n_add;
    logic       o_0_add;
    logic [7:0] o_sb;
    logic       o_sb_add;
    logic       o_sums;
    logic       o_ands;
    logic       o_eors;
    logic       o_ors;
    logic       o_srs;
    logic       o_1_addc;
    logic [7:0] alu_add;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_n;
    logic       rsp_z;
    logic       rsp_c;
    logic       rsp_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
        .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_c(cmd_c),
        .o_db(o_db), .o_db_add(o_db_add), .o_db_n_add(o_db_n_add), .o_0_add(o_0_add),
        .o_sb(o_sb), .o_sb_add(o_sb_add), .o_sums(o_sums), .o_ands(o_ands),
        .o_eors(o_eors), .o_ors(o_ors), .o_srs(o_srs), .o_1_addc(o_1_addc),
        .i_add(alu_add),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_rsp_n(rsp_n), .o_rsp_z(rsp_z), .o_rsp_c(rsp_c), .o_rsp_err(rsp_err)
    );

    // Drive snapshot: [25:18] db, [17:10] sb, 9 db_add, 8 db_n_add, 7 0_add,
    // 6 sb_add, 5 sums, 4 ands, 3 eors, 2 ors, 1 srs, 0 1_addc
    logic [25:0] drv;
    assign drv = {o_db, o_sb, o_db_add, o_db_n_add, o_0_add, o_sb_add,
                  o_sums, o_ands, o_eors, o_ors, o_srs, o_1_addc};

    // Behavioural ALU: A from SB, B from DB or ~DB, ADD register loads on any function strobe.
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    assign alu_a = o_0_add ? 8'h00 : (o_sb_add ? o_sb : 8'h00);
    assign alu_b = o_db_add ? o_db : (o_db_n_add ? ~o_db : 8'h00);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      alu_add <= 8'h00;
        else if (o_sums) alu_add <= alu_a + alu_b + {7'd0, o_1_addc};
        else if (o_ands) alu_add <= alu_a & alu_b;
        else if (o_ors)  alu_add <= alu_a | alu_b;
        else if (o_eors) alu_add <= alu_a ^ alu_b;
        else if (o_srs)  alu_add <= (alu_a & alu_b) >> 1;
    end

    // Operation-level reference: what the 6502 operation means, plus its latency.
    task automatic ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic c, output logic [7:0] r, output logic cy,
                             output logic n, output logic z, output logic err, output int lat);
        int  v;
        logic rot_ok;
`ifdef ALU_SEQUENCER_ROTATE_EN
        rot_ok = 1'b1;
`else
        rot_ok = 1'b0;
`endif
        err = 1'b0;
        cy  = c;
        r   = 8'h00;
        case (op)
            4'd0: begin v = int'(a) + int'(b) + (c ? 1 : 0); r = 8'(v); cy = (v > 255); end
            4'd1: begin v = int'(a) - int'(b) - (c ? 0 : 1); r = 8'(v); cy = (v >= 0); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin r = 8'(int'(a) * 2); cy = a[7]; end
            4'd6: begin r = 8'(int'(a) / 2); cy = a[0]; end
            4'd7: r = 8'(int'(a) + 1);
            4'd8: r = 8'(int'(a) + 255);
            4'd9: begin
                if (rot_ok) begin r = 8'(int'(a) * 2 + (c ? 1 : 0)); cy = a[7]; end
                else err = 1'b1;
            end
            4'd10: begin
                if (rot_ok) begin r = 8'(int'(a) / 2 + (c ? 128 : 0)); cy = a[0]; end
                else err = 1'b1;
            end
            default: err = 1'b1;
        endcase
        if (err) begin
            r   = 8'h00;
            cy  = 1'b0;
            lat = 1;
        end else if (c && (op == 4'd0 || op == 4'd1 || op == 4'd9 || op == 4'd10)) begin
            lat = 4;
        end else begin
            lat = 3;
        end
        n = r[7] & ~err;
        z = (r == 8'h00) & ~err;
    endtask

    // Issue one command, keep presenting junk commands while busy, and report what was observed.
    task automatic do_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input int hold,
                          output int lat, output logic [7:0] data, output logic n,
                          output logic z, output logic cy, output logic err,
                          output logic [25:0] p1, output logic [25:0] p2,
                          output logic stable, output logic busy_ok, output logic idle_ok);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_c     = c;
        rsp_ready = (hold == 0);
        @(posedge clk);
        #1;
        cmd_op  = 4'($urandom_range(0, 15));
        cmd_a   = 8'($urandom_range(0, 255));
        cmd_b   = 8'($urandom_range(0, 255));
        cmd_c   = 1'($urandom_range(0, 1));
        lat     = 0;
        p1      = '0;
        p2      = '0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) p1 = drv;
            if (lat == 2) p2 = drv;
            if (cmd_ready) busy_ok = 1'b0;
        end while (!rsp_valid && lat < 20);
        if (!rsp_valid) lat = -1;
        data   = rsp_data;
        n      = rsp_n;
        z      = rsp_z;
        cy     = rsp_c;
        err    = rsp_err;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || {rsp_data, rsp_n, rsp_z, rsp_c, rsp_err} != {data, n, z, cy, err})
                stable = 1'b0;
            if (cmd_ready) busy_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_ok   = cmd_ready && !rsp_valid;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        cmd_c     = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        tests++; if (drv !== 26'd0) begin fails++; $display("FAIL reset_drive: got %h want 0", drv); end
        tests++; if ({rsp_valid, rsp_data, rsp_n, rsp_z, rsp_c, rsp_err} !== 13'd0) begin
            fails++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_data, rsp_n, rsp_z, rsp_c, rsp_err});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat; logic [7:0] d; logic n, z, cy, err, st, bo, io; logic [25:0] p1, p2;
        do_cmd(4'd0, 8'h7F, 8'h01, 1'b0, 0, lat, d, n, z, cy, err, p1, p2, st, bo, io);
        tests++; if ({d, n, z, cy, err} !== {8'h80, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL add_result: got %h/%b%b%b%b want 80/1000", d, n, z, cy, err);
        end
        tests++; if (lat !== 3) begin fails++; $display("FAIL add_latency: got %0d want 3", lat); end
        tests++; if (p1 !== {8'h01, 8'h7F, 10'b1001100000}) begin
            fails++; $display("FAIL add_pass1_drive: got %h want %h", p1, {8'h01, 8'h7F, 10'b1001100000});
        end
        tests++; if ({bo, io} !== 2'b11) begin fails++; $display("FAIL add_ready_handshake: got %b want 11", {bo, io}); end
    endtask

    task automatic test_add_two_pass();
        int lat; logic [7:0] d; logic n, z, cy, err, st, bo, io; logic [25:0] p1, p2;
        do_cmd(4'd0, 8'hFF, 8'h00, 1'b1, 0, lat, d, n, z, cy, err, p1, p2, st, bo, io);
        tests++; if ({d, n, z, cy, err} !== {8'h00, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            fails++; $display("FAIL add2_result: got %h/%b%b%b%b want 00/0110", d, n, z, cy, err);
        end
        tests++; if (lat !== 4) begin fails++; $display("FAIL add2_latency: got %0d want 4", lat); end
        tests++; if ({p2[25:18], p2[17:10], p2[5]} !== {8'h01, 8'hFF, 1'b1}) begin
            fails++; $display("FAIL add2_pass2_drive: got %h want 01ff1", {p2[25:18], p2[17:10], p2[5]});
        end
    endtask

    task automatic test_sub();
        int lat; logic [7:0] d; logic n, z, cy, err, st, bo, io; logic [25:0] p1, p2;
        do_cmd(4'd1, 8'h10, 8'h20, 1'b1, 0, lat, d, n, z, cy, err, p1, p2, st, bo, io);
        tests++; if ({d, n, cy, err} !== {8'hF0, 1'b1, 1'b0, 1'b0}) begin
            fails++; $display("FAIL sub_result: got %h/%b%b%b want f0/100", d, n, cy, err);
        end
        tests++; if ({p1[25:18], p1[9], p1[8]} !== {8'h20, 1'b0, 1'b1}) begin
            fails++; $display("FAIL sub_pass1_drive: got %h want 201", {p1[25:18], p1[9], p1[8]});
        end
    endtask

    task automatic test_rotate_and_illegal();
        int lat; logic [7:0] d; logic n, z, cy, err, st, bo, io; logic [25:0] p1, p2;
        do_cmd(4'd10, 8'h01, 8'h00, 1'b1, 0, lat, d, n, z, cy, err, p1, p2, st, bo, io);
`ifdef ALU_SEQUENCER_ROTATE_EN
        tests++; if ({d, cy, err, 8'(lat)} !== {8'h80, 1'b1, 1'b0, 8'd4}) begin
            fails++; $display("FAIL ror_result: got %h/%b%b lat %0d want 80/10 lat 4", d, cy, err, lat);
        end
`else
        tests++; if ({d, cy, err, 8'(lat)} !== {8'h00, 1'b0, 1'b1, 8'd1}) begin
            fails++; $display("FAIL ror_disabled: got %h/%b%b lat %0d want 00/01 lat 1", d, cy, err, lat);
        end
`endif
        do_cmd(4'hF, 8'hA5, 8'h5A, 1'b1, 0, lat, d, n, z, cy, err, p1, p2, st, bo, io);
        tests++; if ({d, n, z, cy, err, 8'(lat)} !== {8'h00, 4'b0001, 8'd1}) begin
            fails++; $display("FAIL illegal_op: got %h/%b%b%b%b lat %0d want 00/0001 lat 1", d, n, z, cy, err, lat);
        end
        tests++; if (io !== 1'b1) begin fails++; $display("FAIL illegal_idle_after: got %b want 1", io); end
    endtask

    task automatic test_backpressure();
        int lat; logic [7:0] d; logic n, z, cy, err, st, bo, io; logic [25:0] p1, p2;
        do_cmd(4'd6, 8'h02, 8'h00, 1'b0, 5, lat, d, n, z, cy, err, p1, p2, st, bo, io);
        tests++; if ({d, cy, err} !== {8'h01, 1'b0, 1'b0}) begin
            fails++; $display("FAIL lsr_result: got %h/%b%b want 01/00", d, cy, err);
        end
        tests++; if (st !== 1'b1) begin fails++; $display("FAIL hold_stable: got %b want 1", st); end
        tests++; if ({bo, io} !== 2'b11) begin fails++; $display("FAIL hold_ready: got %b want 11", {bo, io}); end
    endtask

    task automatic test_reset_midflight();
        int lat; logic [7:0] d; logic n, z, cy, err, st, bo, io; logic [25:0] p1, p2;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd7;
        cmd_a     = 8'h33;
        cmd_b     = 8'h00;
        cmd_c     = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        tests++; if ({o_sums, cmd_ready} !== 2'b10) begin
            fails++; $display("FAIL inc_pass1_seen: got %b want 10", {o_sums, cmd_ready});
        end
        rst_n = 1'b0;
        #1;
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b want 1", cmd_ready); end
        tests++; if ({drv, rsp_valid, rsp_data, rsp_n, rsp_z, rsp_c, rsp_err} !== 39'd0) begin
            fails++; $display("FAIL midreset_outputs: got %h want 0", {drv, rsp_valid, rsp_data, rsp_n, rsp_z, rsp_c, rsp_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(4'd2, 8'hF0, 8'h3C, 1'b1, 0, lat, d, n, z, cy, err, p1, p2, st, bo, io);
        tests++; if ({d, cy, err, 8'(lat)} !== {8'h30, 1'b1, 1'b0, 8'd3}) begin
            fails++; $display("FAIL and_after_reset: got %h/%b%b lat %0d want 30/10 lat 3", d, cy, err, lat);
        end
    endtask

    task automatic test_random();
        int lat, elat, hold; logic [7:0] d, ed, a, b; logic [3:0] op;
        logic n, z, cy, err, en, ez, ecy, eerr, c, st, bo, io; logic [25:0] p1, p2;
        for (int i = 0; i < 60; i++) begin
            op   = 4'($urandom_range(0, 15));
            a    = 8'($urandom_range(0, 255));
            b    = 8'($urandom_range(0, 255));
            c    = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 2);
            ref_model(op, a, b, c, ed, ecy, en, ez, eerr, elat);
            do_cmd(op, a, b, c, hold, lat, d, n, z, cy, err, p1, p2, st, bo, io);
            tests++; if ({d, n, z, cy, err} !== {ed, en, ez, ecy, eerr}) begin
                fails++; $display("FAIL rand_result op=%0d a=%h b=%h c=%b: got %h/%b%b%b%b want %h/%b%b%b%b",
                                  op, a, b, c, d, n, z, cy, err, ed, en, ez, ecy, eerr);
            end
            tests++; if (lat !== elat) begin
                fails++; $display("FAIL rand_latency op=%0d c=%b: got %0d want %0d", op, c, lat, elat);
            end
            tests++; if ({p1[7], p1[0], st, bo, io} !== 5'b00111) begin
                fails++; $display("FAIL rand_protocol op=%0d: got %b want 00111", op, {p1[7], p1[0], st, bo, io});
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_two_pass();
        test_sub();
        test_rotate_and_illegal();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Micro-sequencer that sits in front of the cpu6502 ALU and turns one operation request into the ALU control strobes. It drives the A/B input selects, the operand buses and the function strobes for one or two passes, then reads back the ADD hold register. It computes carry, N and Z itself, because the ALU does not drive carry or overflow. It returns the result on a valid/ready response port, which lets a test harness or a future multi-cycle instruction unit run ALU operations without hand-driving every strobe.

## Interface
Parameters: none.

Clock and reset:
- i_clk  in  1  single clock.
- i_reset_n  in  1  asynchronous, active-low reset.

Command port:
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  command accept; high only in IDLE.
- i_cmd_op  in  4  operation code (list under Operation).
- i_cmd_a  in  8  operand A.
- i_cmd_b  in  8  operand B.
- i_cmd_c  in  1  carry in.

ALU drive:
- o_db  out  8  DB bus value.
- o_db_add  out  1  select DB into the B register.
- o_db_n_add  out  1  select inverted DB into the B register.
- o_0_add  out  1  load 0 into the A register; always 0.
- o_sb  out  8  SB bus value.
- o_sb_add  out  1  select SB into the A register.
- o_sums, o_ands, o_eors, o_ors, o_srs  out  1 each  function strobes.
- o_1_addc  out  1  always 0.
- i_add  in  8  ALU ADD register.

Response port:
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  response accept.
- o_rsp_data  out  8  result.
- o_rsp_n  out  1  result[7].
- o_rsp_z  out  1  result==0.
- o_rsp_c  out  1  carry out.
- o_rsp_err  out  1  illegal opcode.

## Operation
- States: IDLE, PASS1, PASS2, CAPTURE, RESP.
- Command accept is `i_cmd_valid & o_cmd_ready`. On accept, op, a, b and c are latched.
- Transitions:
  - Legal op: IDLE→PASS1.
  - Illegal op: IDLE→RESP with err=1 and data, flags = 0.
  - PASS1→PASS2 when a second pass is needed, else PASS1→CAPTURE.
  - PASS2→CAPTURE.
  - CAPTURE→RESP.
  - RESP→IDLE on `i_rsp_ready`.
- In CAPTURE, i_add is registered into the result register. N and Z are derived from that registered value.
- PASS1 drive per op. In every op, SB carries latched a and o_sb_add=1.
  - 0 ADD: DB=b, db_add, sums. Pass2 if c: SB=i_add, DB=0x01, sums. C = bit 8 of a+b+c.
  - 1 SUB: DB=b, db_n_add, sums. Pass2 if c: same as ADD. C = bit 8 of a+~b+c.
  - 2 AND / 3 OR / 4 EOR: DB=b, db_add, and the matching strobe. C = c.
  - 5 ASL: DB=a, db_add, sums. C = a[7].
  - 6 LSR: DB=a, db_add, srs. C = a[0].
  - 7 INC: DB=0x01, db_add, sums. C = c.
  - 8 DEC: DB=0xFF, db_add, sums. C = c.
  - 9 ROL: as ASL. Pass2 if c: SB=i_add, DB=0x01, db_add, ors. C = a[7].
  - 10 ROR: as LSR. Pass2 if c: SB=i_add, DB=0x80, db_add, ors. C = a[0].
  - 11–15: illegal.
- In IDLE, CAPTURE and RESP, all ALU drive outputs are 0.

## Timing
- Accept edge = E0.
- PASS1 is the cycle after E0; the ALU latches at the end of that cycle.
- Single-pass: o_rsp_valid is high 3 cycles after E0.
- Two-pass: o_rsp_valid is high 4 cycles after E0.
- Illegal op: o_rsp_valid is high 1 cycle after E0.
- Response outputs hold stable while `o_rsp_valid & !i_rsp_ready`.
- After the response transfers, the next cycle is IDLE. o_cmd_ready rises then, so there is no back-to-back accept.
- Commands presented while not ready are ignored; no queueing.
- Reset at any time: state→IDLE immediately.
  - o_cmd_ready=1.
  - All other outputs 0, including the result register and flags.
  - Any in-flight op is discarded.

## Configuration
- Macro `ALU_SEQUENCER_ROTATE_EN`.
- Defined: ops 9 (ROL) and 10 (ROR) are legal, as above.
- Undefined: ops 9 and 10 are illegal, giving the 1-cycle error response, and no PASS2 ORS path is built.

## Test plan
- ADD a=0x7F b=0x01 c=0 → data 0x80, N=1, Z=0, C=0, err=0; o_rsp_valid 3 cycles after accept.
- ADD a=0xFF b=0x00 c=1 → data 0x00, Z=1, C=1; o_rsp_valid 4 cycles after accept. PASS2 shows o_sb=0xFF, o_db=0x01, o_sums=1.
- SUB a=0x10 b=0x20 c=1 → data 0xF0, N=1, C=0. PASS1 shows o_db_n_add=1, o_db=0x20.
- ROR a=0x01 c=1 with macro defined → data 0x80, C=1. With macro undefined → err=1, data 0x00, valid 1 cycle after accept. Op 0xF → err=1 in both builds.
- LSR a=0x02 c=0, i_rsp_ready held low 5 cycles → data 0x01, C=0, held stable. o_cmd_ready stays 0 until the cycle after the transfer.
- INC a=0x33, reset asserted during PASS1 → next cycle IDLE, o_cmd_ready=1, all strobes/o_rsp_* = 0. A new ANDs a=0xF0 b=0x3C c=1 after reset → data 0x30, C=1.
